pipe_ctrl: RTL and testbench

Sequencing controller for the three-stage pipeline (fetch/PC → decode/register file → execute/memory/write-back). It detects load-use hazards between the decode stage and the execute stage, and inserts stall bubbles for them. It also squashes wrong-path fetches after a taken `brz`/`brn`/`j`, fills the pipeline after reset, and parks the core on a halt request. It sits beside the stage instances in the top level and drives their enables; it also exposes saturating stall and flush counters.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/hazard_detect.sv | 32 +++
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FILL  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STALL = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } pipe_state_t;

  localparam int REG_W_DEF = 6;

  localparam int INSN_W = 32;
  localparam logic [INSN_W-1:0] NOP = '0;

  localparam int LOAD_LAT_MIN     = 1;
  localparam int LOAD_LAT_MAX     = 4;
  localparam int FLUSH_CYCLES_MIN = 1;
  localparam int FLUSH_CYCLES_MAX = 3;

  // Last value of the fill counter; FILL lasts FILL_LAST+1 cycles.
  localparam logic [1:0] FILL_LAST = 2'd1;

  function automatic logic [1:0] extra_cycles(input int n);
    return 2'(n - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the decode and execute stages.
`default_nettype none

module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs,
  input  logic [REG_W-1:0] dec_rt,
  input  logic             dec_use_rs,
  input  logic             dec_use_rt,
  input  logic             ex_valid,
  input  logic             ex_regw,
  input  logic             ex_memr,
  input  logic [REG_W-1:0] ex_rd,
  output logic             hz
);

  logic ex_load;
  logic src_match;

  // Register 0 is compared like any other index.
  assign ex_load   = ex_valid & ex_memr & ex_regw;
  assign src_match = (dec_use_rs & (dec_rs == ex_rd)) |
                     (dec_use_rt & (dec_rt == ex_rd));
  assign hz        = dec_valid & ex_load & src_match;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: fill, load-use stall, branch squash, halt,
// plus saturating stall/flush event counters.
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W        = REG_W_DEF,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs,
  input  logic [REG_W-1:0] dec_rt,
  input  logic             dec_use_rs,
  input  logic             dec_use_rt,
  input  logic             dec_br_taken,
  input  logic             ex_valid,
  input  logic             ex_regw,
  input  logic             ex_memr,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] STALL_CNT_INIT = extra_cycles(LOAD_LAT);
  localparam logic [1:0] FLUSH_CNT_INIT = extra_cycles(FLUSH_CYCLES);

  pipe_state_t state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic        halt_pend, halt_pend_nxt;
  logic        hz;
  logic        stall_inc;
  logic        flush_inc;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .dec_valid  (dec_valid),
    .dec_rs     (dec_rs),
    .dec_rt     (dec_rt),
    .dec_use_rs (dec_use_rs),
    .dec_use_rt (dec_use_rt),
    .ex_valid   (ex_valid),
    .ex_regw    (ex_regw),
    .ex_memr    (ex_memr),
    .ex_rd      (ex_rd),
    .hz         (hz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      cnt       <= 2'd0;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      halt_pend <= halt_pend_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    halt_pend_nxt = halt_pend;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    halted        = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    case (state)
      ST_FILL: begin
        idex_bubble = 1'b1;
        if (halt_req) halt_pend_nxt = 1'b1;
        if (cnt == FILL_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = 2'd0;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end

      ST_RUN: begin
        // Hazard outranks the branch: the branch re-evaluates once its operand is ready.
        if (hz) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
          if (LOAD_LAT > 1) begin
            state_nxt = ST_STALL;
            cnt_nxt   = STALL_CNT_INIT;
          end
        end else if (dec_br_taken) begin
          ifid_flush = 1'b1;
          flush_inc  = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = FLUSH_CNT_INIT;
          end
        end else if (halt_req || halt_pend) begin
          state_nxt = ST_HALT;
        end
      end

      ST_STALL: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        stall_inc   = 1'b1;
        if (halt_req) halt_pend_nxt = 1'b1;
        if (cnt == 2'd1) state_nxt = ST_RUN;
        cnt_nxt = cnt - 2'd1;
      end

      ST_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (halt_req) halt_pend_nxt = 1'b1;
        if (cnt == 2'd1) state_nxt = ST_RUN;
        cnt_nxt = cnt - 2'd1;
      end

      ST_HALT: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end

      default: begin
        state_nxt = ST_FILL;
        cnt_nxt   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: instance a (LOAD_LAT=1, FLUSH_CYCLES=2, 32-bit
// counters) and instance b (LOAD_LAT=3, FLUSH_CYCLES=1, 2-bit counters).
`default_nettype none

module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dec_valid, dec_use_rs, dec_use_rt, dec_br_taken;
  logic [5:0] dec_rs, dec_rt, ex_rd;
  logic       ex_valid, ex_regw, ex_memr, halt_req;

  logic        pc_en_a, ifid_en_a, ifid_flush_a, idex_bubble_a, halted_a;
  logic [31:0] stall_cnt_a, flush_cnt_a;
  logic        pc_en_b, ifid_en_b, ifid_flush_b, idex_bubble_b, halted_b;
  logic [1:0]  stall_cnt_b, flush_cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_W(6), .LOAD_LAT(1), .FLUSH_CYCLES(2), .CNT_W(32)) u_a (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_br_taken(dec_br_taken),
    .ex_valid(ex_valid), .ex_regw(ex_regw), .ex_memr(ex_memr), .ex_rd(ex_rd),
    .halt_req(halt_req),
    .pc_en(pc_en_a), .ifid_en(ifid_en_a), .ifid_flush(ifid_flush_a),
    .idex_bubble(idex_bubble_a), .halted(halted_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipe_ctrl #(.REG_W(6), .LOAD_LAT(3), .FLUSH_CYCLES(1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_br_taken(dec_br_taken),
    .ex_valid(ex_valid), .ex_regw(ex_regw), .ex_memr(ex_memr), .ex_rd(ex_rd),
    .halt_req(halt_req),
    .pc_en(pc_en_b), .ifid_en(ifid_en_b), .ifid_flush(ifid_flush_b),
    .idex_bubble(idex_bubble_b), .halted(halted_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    dec_valid = 0; dec_use_rs = 0; dec_use_rt = 0; dec_br_taken = 0;
    dec_rs = 0; dec_rt = 0; ex_rd = 0;
    ex_valid = 0; ex_regw = 0; ex_memr = 0; halt_req = 0;
  endtask

  task automatic load_use_r5;
    dec_valid = 1; dec_rs = 6'd5; dec_use_rs = 1;
    ex_valid = 1; ex_memr = 1; ex_regw = 1; ex_rd = 6'd5;
  endtask

  // Leaves both instances in their first RUN cycle.
  task automatic reset_dut;
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick(); tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 0;
    tick();
    sample();
    total++; if (pc_en_a !== 1'b1) begin bad++; $display("FAIL reset_pc_en: got %b want 1", pc_en_a); end
    total++; if (ifid_en_a !== 1'b1) begin bad++; $display("FAIL reset_ifid_en: got %b want 1", ifid_en_a); end
    total++; if (ifid_flush_a !== 1'b0) begin bad++; $display("FAIL reset_ifid_flush: got %b want 0", ifid_flush_a); end
    total++; if (idex_bubble_a !== 1'b1) begin bad++; $display("FAIL reset_bubble: got %b want 1", idex_bubble_a); end
    total++; if (halted_a !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted_a); end
    total++; if (stall_cnt_a !== 32'd0 || flush_cnt_a !== 32'd0) begin bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt_a, flush_cnt_a); end
    tick();
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      sample();
      total++; if (idex_bubble_a !== 1'b1 || pc_en_a !== 1'b1) begin bad++; $display("FAIL fill_cycle%0d: bubble=%b pc_en=%b want 1/1", i, idex_bubble_a, pc_en_a); end
      tick();
    end
    sample();
    total++; if (idex_bubble_a !== 1'b0) begin bad++; $display("FAIL fill_done_bubble: got %b want 0", idex_bubble_a); end
    total++; if (pc_en_a !== 1'b1 || ifid_en_a !== 1'b1 || ifid_flush_a !== 1'b0 || halted_a !== 1'b0) begin
      bad++; $display("FAIL fill_done_run: pc_en=%b ifid_en=%b flush=%b halted=%b want 1/1/0/0", pc_en_a, ifid_en_a, ifid_flush_a, halted_a);
    end
    tick();
  endtask

  task automatic test_load_use;
    reset_dut();
    load_use_r5();
    sample();
    total++; if (pc_en_a !== 1'b0 || ifid_en_a !== 1'b0 || idex_bubble_a !== 1'b1) begin
      bad++; $display("FAIL hz_rs_gate: pc_en=%b ifid_en=%b bubble=%b want 0/0/1", pc_en_a, ifid_en_a, idex_bubble_a);
    end
    tick();
    ex_valid = 0;
    sample();
    total++; if (pc_en_a !== 1'b1 || idex_bubble_a !== 1'b0) begin bad++; $display("FAIL hz_rs_release: pc_en=%b bubble=%b want 1/0", pc_en_a, idex_bubble_a); end
    total++; if (stall_cnt_a !== 32'd1) begin bad++; $display("FAIL hz_rs_stall_cnt: got %0d want 1", stall_cnt_a); end
    tick();
    // Register 0 on the rt path still counts as a hazard.
    dec_use_rs = 0; dec_use_rt = 1; dec_rt = 6'd0; ex_rd = 6'd0; ex_valid = 1;
    sample();
    total++; if (pc_en_a !== 1'b0) begin bad++; $display("FAIL hz_rt_r0: pc_en=%b want 0", pc_en_a); end
    tick();
    ex_memr = 0;
    sample();
    total++; if (pc_en_a !== 1'b1 || idex_bubble_a !== 1'b0) begin bad++; $display("FAIL raw_nonload: pc_en=%b bubble=%b want 1/0", pc_en_a, idex_bubble_a); end
    tick();
    ex_memr = 1; dec_use_rt = 0;
    sample();
    total++; if (pc_en_a !== 1'b1) begin bad++; $display("FAIL unused_src: pc_en=%b want 1", pc_en_a); end
    tick();
    idle_inputs();
    sample();
    total++; if (stall_cnt_a !== 32'd2) begin bad++; $display("FAIL hz_total_stall_cnt: got %0d want 2", stall_cnt_a); end
    tick();
  endtask

  task automatic test_load_lat3_saturate;
    reset_dut();
    for (int rep = 0; rep < 2; rep++) begin
      load_use_r5();
      for (int i = 0; i < 5; i++) begin
        logic exp_pc;
        exp_pc = (i < 3) ? 1'b0 : 1'b1;
        sample();
        total++; if (pc_en_b !== exp_pc || idex_bubble_b !== ~exp_pc) begin
          bad++; $display("FAIL lat3_rep%0d_cyc%0d: pc_en=%b bubble=%b want %b/%b", rep, i, pc_en_b, idex_bubble_b, exp_pc, ~exp_pc);
        end
        tick();
        if (i == 0) ex_valid = 0;
      end
      sample();
      total++; if (stall_cnt_b !== 2'd3) begin bad++; $display("FAIL lat3_stall_cnt_rep%0d: got %0d want 3", rep, stall_cnt_b); end
      tick();
      idle_inputs();
    end
  endtask

  task automatic test_branch;
    reset_dut();
    dec_valid = 1; dec_br_taken = 1;
    sample();
    total++; if (ifid_flush_a !== 1'b1 || idex_bubble_a !== 1'b0 || pc_en_a !== 1'b1 || ifid_en_a !== 1'b1) begin
      bad++; $display("FAIL br_detect: flush=%b bubble=%b pc_en=%b ifid_en=%b want 1/0/1/1", ifid_flush_a, idex_bubble_a, pc_en_a, ifid_en_a);
    end
    tick();
    dec_br_taken = 0;
    sample();
    total++; if (ifid_flush_a !== 1'b1 || idex_bubble_a !== 1'b1 || pc_en_a !== 1'b1) begin
      bad++; $display("FAIL br_flush_slot2: flush=%b bubble=%b pc_en=%b want 1/1/1", ifid_flush_a, idex_bubble_a, pc_en_a);
    end
    total++; if (ifid_flush_b !== 1'b0 || idex_bubble_b !== 1'b0) begin bad++; $display("FAIL br_single_slot: flush=%b bubble=%b want 0/0", ifid_flush_b, idex_bubble_b); end
    tick();
    sample();
    total++; if (ifid_flush_a !== 1'b0 || idex_bubble_a !== 1'b0) begin bad++; $display("FAIL br_done: flush=%b bubble=%b want 0/0", ifid_flush_a, idex_bubble_a); end
    total++; if (flush_cnt_a !== 32'd1 || stall_cnt_a !== 32'd0) begin bad++; $display("FAIL br_counters: got %0d/%0d want 0/1", stall_cnt_a, flush_cnt_a); end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back;
    reset_dut();
    load_use_r5();
    dec_br_taken = 1;
    sample();
    total++; if (pc_en_a !== 1'b0 || ifid_flush_a !== 1'b0 || idex_bubble_a !== 1'b1) begin
      bad++; $display("FAIL hzbr_stall_first: pc_en=%b flush=%b bubble=%b want 0/0/1", pc_en_a, ifid_flush_a, idex_bubble_a);
    end
    tick();
    ex_valid = 0;
    sample();
    total++; if (ifid_flush_a !== 1'b1 || idex_bubble_a !== 1'b0 || pc_en_a !== 1'b1) begin
      bad++; $display("FAIL hzbr_branch_after: flush=%b bubble=%b pc_en=%b want 1/0/1", ifid_flush_a, idex_bubble_a, pc_en_a);
    end
    tick();
    dec_br_taken = 0;
    sample();
    total++; if (ifid_flush_a !== 1'b1 || idex_bubble_a !== 1'b1) begin bad++; $display("FAIL hzbr_flush_slot: flush=%b bubble=%b want 1/1", ifid_flush_a, idex_bubble_a); end
    tick();
    sample();
    total++; if (stall_cnt_a !== 32'd1 || flush_cnt_a !== 32'd1 || ifid_flush_a !== 1'b0) begin
      bad++; $display("FAIL hzbr_counters: stall=%0d flush=%0d ifid_flush=%b want 1/1/0", stall_cnt_a, flush_cnt_a, ifid_flush_a);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_halt_busy;
    reset_dut();
    load_use_r5();
    sample();
    total++; if (pc_en_b !== 1'b0) begin bad++; $display("FAIL halt_hz_start: pc_en=%b want 0", pc_en_b); end
    tick();
    ex_valid = 0; halt_req = 1;
    sample();
    total++; if (halted_b !== 1'b0 || pc_en_b !== 1'b0) begin bad++; $display("FAIL halt_in_stall: halted=%b pc_en=%b want 0/0", halted_b, pc_en_b); end
    tick();
    halt_req = 0;
    sample();
    total++; if (halted_b !== 1'b0 || idex_bubble_b !== 1'b1) begin bad++; $display("FAIL halt_stall_tail: halted=%b bubble=%b want 0/1", halted_b, idex_bubble_b); end
    tick();
    sample();
    total++; if (halted_b !== 1'b0 || pc_en_b !== 1'b1 || idex_bubble_b !== 1'b0) begin
      bad++; $display("FAIL halt_clean_run: halted=%b pc_en=%b bubble=%b want 0/1/0", halted_b, pc_en_b, idex_bubble_b);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      sample();
      total++; if (halted_b !== 1'b1 || pc_en_b !== 1'b0 || ifid_en_b !== 1'b0 || idex_bubble_b !== 1'b1) begin
        bad++; $display("FAIL halt_held%0d: halted=%b pc_en=%b ifid_en=%b bubble=%b want 1/0/0/1", i, halted_b, pc_en_b, ifid_en_b, idex_bubble_b);
      end
      tick();
    end
    #2;
    rst_n = 0;
    #1;
    total++; if (halted_b !== 1'b0 || pc_en_b !== 1'b1 || idex_bubble_b !== 1'b1 || stall_cnt_b !== 2'd0) begin
      bad++; $display("FAIL async_reset: halted=%b pc_en=%b bubble=%b stall_cnt=%0d want 0/1/1/0", halted_b, pc_en_b, idex_bubble_b, stall_cnt_b);
    end
    total++; if (halted_a !== 1'b0) begin bad++; $display("FAIL async_reset_a: halted=%b want 0", halted_a); end
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_load_lat3_saturate();
    test_branch();
    test_back_to_back();
    test_halt_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
